// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM output stage: maps a signed PID correction to a 1-2 ms pulse in a fixed frame.
// New corrections are double-buffered and take effect only at frame start; sample_o kicks the next PID cycle.
module servo_pwm_gen #(
  parameter int WIDTH      = 12,
  parameter int CNT_W      = 20,
  parameter int PERIOD_CNT = 1000000,
  parameter int MIN_CNT    = 50000,
  parameter int MAX_CNT    = 100000,
  parameter int CENTER_CNT = 75000,
  parameter int SHIFT      = 4
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic [2*WIDTH-1:0] u_i,
  input  logic               u_valid_i,
  output logic               sample_o,
  output logic               pwm_o,
  output logic [CNT_W-1:0]   width_o,
  output logic               sat_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(PERIOD_CNT - 1);
  localparam logic [CNT_W-1:0] LP_CENTER = CNT_W'(CENTER_CNT);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_active, w_active_nxt;
  logic [CNT_W-1:0]   r_shadow;
  logic               r_valid_q, r_pwm, r_sample, r_sat;
  logic               w_edge, w_load, w_map_sat;
  logic signed [31:0] w_u_ext, w_off, w_sum;
  logic [CNT_W-1:0]   w_map;

  assign w_edge  = u_valid_i & ~r_valid_q;
  assign w_u_ext = {{(32-2*WIDTH){u_i[2*WIDTH-1]}}, u_i};
  assign w_off   = w_u_ext >>> SHIFT;
  assign w_sum   = CENTER_CNT + w_off;

  always_comb begin
    w_map     = CNT_W'(w_sum);
    w_map_sat = 1'b0;
    if (w_sum > MAX_CNT) begin
      w_map     = CNT_W'(MAX_CNT);
      w_map_sat = 1'b1;
    end else if (w_sum < MIN_CNT) begin
      w_map     = CNT_W'(MIN_CNT);
      w_map_sat = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (enable_i) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == LP_LAST) begin
          w_cnt_nxt = '0;
          // enable_i only matters here, so a frame is never cut short
          if (enable_i) w_load = 1'b1;
          else          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A capture coinciding with the frame boundary goes straight to the new frame.
  always_comb begin
    w_active_nxt = r_active;
    if (w_load) w_active_nxt = w_edge ? w_map : r_shadow;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are registered from next-state values so they line up with r_cnt.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_q <= 1'b0;
      r_shadow  <= LP_CENTER;
      r_sat     <= 1'b0;
      r_active  <= LP_CENTER;
      r_pwm     <= 1'b0;
      r_sample  <= 1'b0;
    end else begin
      r_valid_q <= u_valid_i;
      if (w_edge) begin
        r_shadow <= w_map;
        r_sat    <= w_map_sat;
      end
      r_active <= w_active_nxt;
      r_pwm    <= (w_state_nxt == S_RUN) && (w_cnt_nxt < w_active_nxt);
      r_sample <= (w_state_nxt == S_RUN) && (w_cnt_nxt == '0);
    end
  end

  assign pwm_o    = r_pwm;
  assign sample_o = r_sample;
  assign width_o  = r_active;
  assign sat_o    = r_sat;

endmodule
